recv: RTL and testbench

- Read-side companion to the FIFO write-side feeder. Pulls bytes out of the async FIFO read port in the clk_r domain and presents them downstream on a valid/ready stream.
- Issues FIFO reads only when it has buffer credit. A byte popped from the FIFO is never dropped under downstream backpressure.
- Sits between the async FIFO read port and the read-domain consumer.

---
 rtl/recv.sv | 126 ++++++++++++
 tb/tb_recv.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/recv.sv
// recv: drains an async FIFO read port into a valid/ready stream through a credit-guarded skid buffer.
// Define RECV_CNT_EN to add the 16-bit accepted-word counter output rx_cnt.
module recv #(
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk_r,
    input  logic          reset,
    input  logic          empty,
    input  logic [DW-1:0] data_r,
    output logic          rd_en,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          underrun
`ifdef RECV_CNT_EN
    ,
    output logic [15:0]   rx_cnt
);
`else
);
`endif

    localparam int DEPTH = RD_LAT + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        STALL  = 2'd3
    } state_t;

    logic [DW-1:0]     r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic [RD_LAT-1:0] r_pipe;
    logic [DW-1:0]     r_data_o;
    logic              r_underrun;
    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_pop;
    logic              w_push;
    logic [RD_LAT-1:0] w_pipe_nxt;
    logic [CW-1:0]     w_credit;
    logic [CW-1:0]     w_count_nxt;
    logic [PW-1:0]     w_head_nxt;

    function automatic logic [CW-1:0] ones(input logic [RD_LAT-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < RD_LAT; i++) n = n + CW'(v[i]);
        return n;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit counts words already buffered plus words still in the FIFO read pipe.
    assign w_pop       = valid_o & ready_i;
    assign w_push      = r_pipe[RD_LAT-1];
    assign w_credit    = r_count + ones(r_pipe) - CW'(w_pop);
    assign rd_en       = !reset & !empty & (w_credit < CW'(DEPTH));
    assign w_pipe_nxt  = RD_LAT'({r_pipe, rd_en});
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_head_nxt  = w_pop ? ptr_inc(r_head) : r_head;

    // Both buffered states mean count != 0, so the status register doubles as valid.
    assign valid_o  = (r_state == STREAM) || (r_state == STALL);
    assign data_o   = r_data_o;
    assign underrun = r_underrun;

    always_ff @(posedge clk_r) begin
        if (reset) begin
            r_count    <= '0;
            r_pipe     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_data_o   <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_pipe  <= w_pipe_nxt;
            r_head  <= w_head_nxt;
            if (w_push) r_tail <= ptr_inc(r_tail);
            // When the buffer drains to the incoming word, bypass the memory.
            if (w_count_nxt != '0)
                r_data_o <= (r_count == CW'(w_pop)) ? data_r : r_mem[w_head_nxt];
            if (empty && ready_i && (r_count == '0) && (ones(r_pipe) == '0))
                r_underrun <= 1'b1;
        end
    end

    always_ff @(posedge clk_r) begin
        if (w_push) r_mem[r_tail] <= data_r;
    end

    always_ff @(posedge clk_r) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = IDLE;
        if (w_count_nxt != '0)
            w_state_nxt = ready_i ? STREAM : STALL;
        else if (ones(w_pipe_nxt) != '0)
            w_state_nxt = FETCH;
    end

`ifdef RECV_CNT_EN
    logic [15:0] r_rx_cnt;

    always_ff @(posedge clk_r) begin
        if (reset)      r_rx_cnt <= '0;
        else if (w_pop) r_rx_cnt <= r_rx_cnt + 16'd1;
    end

    assign rx_cnt = r_rx_cnt;
`endif

endmodule

// File: tb/tb_recv.sv
// tb_recv: two recv lanes (RD_LAT=1 and RD_LAT=2) fed by behavioural FIFOs and checked against an in-order scoreboard.
module tb_recv;
    localparam int ST_IDLE  = 0;
    localparam int ST_STALL = 3;

    logic clk_r = 1'b0;
    always #5 clk_r = ~clk_r;

    logic       reset;
    logic       ready_s    [2];
    logic       empty_s    [2];
    logic [7:0] data_r_s   [2];
    logic       rd_en_s    [2];
    logic [7:0] data_o_s   [2];
    logic       valid_s    [2];
    logic       underrun_s [2];
`ifdef RECV_CNT_EN
    logic [15:0] rx_cnt_s  [2];
`endif

    int cnt_h [2];
    int push_h [2];
    int state_h [2];
    int head_h [2];
    int tail_h [2];
    int rdp [2];

    logic [7:0] fmem [2][256];
    int fwr [2];
    int exp_idx [2];
    int pops [2];
    int n_chk = 0;
    int n_pass = 0;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        int rp = 0;
        logic [7:0] st1;

        recv #(.DW(8), .RD_LAT(g + 1)) u_dut (
            .clk_r    (clk_r),
            .reset    (reset),
            .empty    (empty_s[g]),
            .data_r   (data_r_s[g]),
            .rd_en    (rd_en_s[g]),
            .data_o   (data_o_s[g]),
            .valid_o  (valid_s[g]),
            .ready_i  (ready_s[g]),
`ifdef RECV_CNT_EN
            .rx_cnt   (rx_cnt_s[g]),
`endif
            .underrun (underrun_s[g])
        );

        always @(posedge clk_r) begin
            if (rd_en_s[g]) begin
                st1 <= fmem[g][rp % 256];
                rp  <= rp + 1;
            end
        end

        if (g == 0) begin : g_lat1
            assign data_r_s[g] = st1;
        end else begin : g_lat2
            logic [7:0] st2;
            always @(posedge clk_r) st2 <= st1;
            assign data_r_s[g] = st2;
        end

        assign empty_s[g] = (rp == fwr[g]);
        assign rdp[g]     = rp;
        assign cnt_h[g]   = int'(u_dut.r_count);
        assign push_h[g]  = int'(u_dut.r_pipe[g]);
        assign state_h[g] = int'(u_dut.r_state);
        assign head_h[g]  = int'(u_dut.r_head);
        assign tail_h[g]  = int'(u_dut.r_tail);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Per-cycle scoreboard: every accepted word must be the next word written into that lane's FIFO.
    task automatic mon();
        for (int g = 0; g < 2; g++) begin
`ifdef RECV_CNT_EN
            if (reset === 1'b0) chk($sformatf("rx_cnt%0d", g), rx_cnt_s[g], pops[g] % 65536);
`endif
            if (valid_s[g] === 1'b1 && ready_s[g] === 1'b1 && reset === 1'b0) begin
                chk($sformatf("data%0d_w%0d", g, exp_idx[g]), data_o_s[g], fmem[g][exp_idx[g] % 256]);
                exp_idx[g]++;
                pops[g]++;
            end
            chk($sformatf("count_bound%0d", g), cnt_h[g] <= g + 2, 1);
            chk($sformatf("push_when_full%0d", g), (push_h[g] == 1) && (cnt_h[g] == g + 2), 0);
        end
    endtask

    task automatic settle();
        #1;
        mon();
    endtask

    task automatic load(input int g, input logic [7:0] b);
        fmem[g][fwr[g] % 256] = b;
        fwr[g]++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        ready_s[0] = 1'b0;
        ready_s[1] = 1'b0;
        repeat (n) begin
            settle();
            @(negedge clk_r);
        end
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            exp_idx[g] = rdp[g];
            pops[g] = 0;
        end
    endtask

    initial begin
        logic [7:0] exp_rd;
        logic [7:0] exp_vld;
        logic [7:0] exp_und;
        int base;
        int wraps;
        int prev_tail;
        int waited;

        reset = 1'b1;
        ready_s[0] = 1'b0;
        ready_s[1] = 1'b0;
        fwr[0] = 0; fwr[1] = 0;
        exp_idx[0] = 0; exp_idx[1] = 0;
        pops[0] = 0; pops[1] = 0;
        @(negedge clk_r);
        do_reset(3);

        // Idle after reset: FIFOs empty, downstream not ready.
        for (int k = 0; k < 10; k++) begin
            settle();
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("idle_rd_en%0d", g), rd_en_s[g], 0);
                chk($sformatf("idle_valid%0d", g), valid_s[g], 0);
                chk($sformatf("idle_data%0d", g), data_o_s[g], 0);
                chk($sformatf("idle_underrun%0d", g), underrun_s[g], 0);
                chk($sformatf("idle_state%0d", g), state_h[g], ST_IDLE);
            end
            @(negedge clk_r);
        end

        // Lane 0 (RD_LAT=1): four preloaded words, ready held high; ends with an underrun.
        exp_rd  = 8'b0000_1111;
        exp_vld = 8'b0011_1100;
        exp_und = 8'b1000_0000;
        ready_s[0] = 1'b1;
        load(0, 8'h11); load(0, 8'h22); load(0, 8'h33); load(0, 8'h44);
        for (int k = 0; k < 8; k++) begin
            settle();
            chk($sformatf("stream_rd_en_c%0d", k), rd_en_s[0], exp_rd[k]);
            chk($sformatf("stream_valid_c%0d", k), valid_s[0], exp_vld[k]);
            chk($sformatf("stream_underrun_c%0d", k), underrun_s[0], exp_und[k]);
            @(negedge clk_r);
        end
        load(0, 8'h55); load(0, 8'h66);
        for (int k = 0; k < 6; k++) begin
            settle();
            chk($sformatf("underrun_sticky_c%0d", k), underrun_s[0], 1);
            @(negedge clk_r);
        end

        // Same stream with backpressure while 0x22 is presented.
        do_reset(1);
        base = exp_idx[0];
        ready_s[0] = 1'b1;
        load(0, 8'h11); load(0, 8'h22); load(0, 8'h33); load(0, 8'h44);
        for (int k = 0; k < 14; k++) begin
            ready_s[0] = !(k >= 3 && k <= 7);
            settle();
            if (k == 0) chk("underrun_cleared", underrun_s[0], 0);
            if (k >= 3 && k <= 7) begin
                chk($sformatf("stall_data_c%0d", k), data_o_s[0], 8'h22);
                chk($sformatf("stall_valid_c%0d", k), valid_s[0], 1);
                chk($sformatf("stall_rd_en_c%0d", k), rd_en_s[0], 0);
            end
            if (k >= 4 && k <= 7) chk($sformatf("stall_state_c%0d", k), state_h[0], ST_STALL);
            if (k == 8) chk("release_rd_en", rd_en_s[0], 1);
            @(negedge clk_r);
        end
        chk("stall_delivered", exp_idx[0] - base, 4);

        // Lane 1 (RD_LAT=2): eight random words, ready toggling every cycle.
        do_reset(1);
        base = exp_idx[1];
        wraps = 0;
        prev_tail = 0;
        for (int i = 0; i < 8; i++) load(1, 8'($urandom));
        for (int k = 0; k < 40; k++) begin
            ready_s[1] = (k % 2 == 0);
            settle();
            if (tail_h[1] == 0 && prev_tail == 2) wraps++;
            prev_tail = tail_h[1];
            @(negedge clk_r);
        end
        chk("toggle_delivered", exp_idx[1] - base, 8);
        chk("toggle_tail_wraps", wraps, 8 / 3);
        chk("toggle_tail_ptr", tail_h[1], 8 % 3);
        chk("toggle_head_ptr", head_h[1], 8 % 3);

        // Random writes and random backpressure on both lanes, then drain.
        do_reset(1);
        for (int k = 0; k < 400; k++) begin
            for (int g = 0; g < 2; g++) begin
                if ($urandom_range(0, 1) == 1 && (fwr[g] - rdp[g]) < 200) load(g, 8'($urandom));
                ready_s[g] = ($urandom_range(0, 3) != 0);
            end
            settle();
            @(negedge clk_r);
        end
        ready_s[0] = 1'b1;
        ready_s[1] = 1'b1;
        repeat (20) begin
            settle();
            @(negedge clk_r);
        end
        chk("random_drained0", exp_idx[0], fwr[0]);
        chk("random_drained1", exp_idx[1], fwr[1]);

        // Reset while two words sit in lane 0's buffer.
        do_reset(1);
        load(0, 8'hA1); load(0, 8'hA2); load(0, 8'hA3); load(0, 8'hA4);
        waited = 0;
        settle();
        while (cnt_h[0] != 2 && waited < 10) begin
            @(negedge clk_r);
            settle();
            waited++;
        end
        chk("midreset_buffered", cnt_h[0], 2);
        @(negedge clk_r);
        do_reset(1);
        settle();
        chk("midreset_valid", valid_s[0], 0);
        chk("midreset_state", state_h[0], ST_IDLE);
        @(negedge clk_r);
        ready_s[0] = 1'b1;
        repeat (10) begin
            settle();
            @(negedge clk_r);
        end
        chk("midreset_rest_delivered", exp_idx[0], fwr[0]);

`ifdef RECV_CNT_EN
        // 65537 accepted words wrap the counter to 1.
        do_reset(1);
        ready_s[0] = 1'b1;
        waited = 0;
        while (pops[0] < 65537 && waited < 70000) begin
            if ((fwr[0] - rdp[0]) < 8) load(0, 8'($urandom));
            settle();
            @(negedge clk_r);
            waited++;
        end
        ready_s[0] = 1'b0;
        settle();
        chk("cnt_pops", pops[0], 65537);
        chk("cnt_wrap", rx_cnt_s[0], 16'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
